// File: rtl/ntt_radix2_scheduler.sv
// Address/control sequencer for an in-place radix-2 NTT/INTT.
// One butterfly is issued per cycle. Each stage is followed by a drain
// window of PIPE_LAT cycles, so the last write of a stage lands before
// the next stage starts reading.
module ntt_radix2_scheduler #(
  parameter int LOG_N    = 3,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LOG_N-1:0] stage_o,
  output logic             rd_en_o,
  output logic [LOG_N-1:0] rd_addr_1_o,
  output logic [LOG_N-1:0] rd_addr_2_o,
  output logic [LOG_N-1:0] tw_addr_o,
  output logic             bf_select_o,
  output logic             wr_en_o,
  output logic [LOG_N-1:0] wr_addr_1_o,
  output logic [LOG_N-1:0] wr_addr_2_o
);

  localparam int              HALF   = 1 << (LOG_N - 1);
  localparam int              CW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);
  localparam logic [LOG_N-1:0] LAST_S = LOG_N'(LOG_N - 1);
  localparam logic [LOG_N-1:0] LAST_J = LOG_N'(HALF - 1);
  localparam logic [CW-1:0]    LAST_C = CW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // log2 of the butterfly span m: NTT shrinks the span per stage, INTT grows it
  function automatic logic [LOG_N-1:0] span_shift(input logic md, input logic [LOG_N-1:0] s);
    return md ? s : (LAST_S - s);
  endfunction

  // a1 = 2*m*(j/m) + j%m, with m a power of two
  function automatic logic [LOG_N-1:0] top_addr(input logic [LOG_N-1:0] j,
                                               input logic [LOG_N-1:0] sh);
    logic [LOG_N-1:0] lo_mask;
    lo_mask = (ONE << sh) - ONE;
    return ((j >> sh) << (sh + ONE)) | (j & lo_mask);
  endfunction

  // Twiddle base is N/(2m) in both directions; group index g = j/m is added on top
  function automatic logic [LOG_N-1:0] tw_index(input logic [LOG_N-1:0] j,
                                               input logic [LOG_N-1:0] sh);
    return (ONE << (LAST_S - sh)) + (j >> sh);
  endfunction

  state_t           state_q, state_d;
  logic [LOG_N-1:0] s_q, s_d;
  logic [LOG_N-1:0] j_q, j_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sel_q, sel_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_a1_q, rd_a1_d;
  logic [LOG_N-1:0] rd_a2_q, rd_a2_d;
  logic [LOG_N-1:0] tw_q, tw_d;

  logic             iss;
  logic             iss_md;
  logic [LOG_N-1:0] iss_s;
  logic [LOG_N-1:0] iss_j;
  logic [LOG_N-1:0] iss_sh;

  logic [PIPE_LAT-1:0] en_dly_q;
  logic [LOG_N-1:0]    a1_dly_q [PIPE_LAT];
  logic [LOG_N-1:0]    a2_dly_q [PIPE_LAT];

  // Next-state and next-output logic; iss marks a butterfly issued next cycle
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sel_d   = sel_q;
    iss     = 1'b0;
    iss_md  = sel_q;
    iss_s   = s_q;
    iss_j   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_READ;
          s_d     = '0;
          j_d     = '0;
          sel_d   = mode_i;
          busy_d  = 1'b1;
          iss     = 1'b1;
          iss_md  = mode_i;
          iss_s   = '0;
          iss_j   = '0;
        end
      end
      S_READ: begin
        if (j_q == LAST_J) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          j_d   = j_q + ONE;
          iss   = 1'b1;
          iss_j = j_q + ONE;
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_C) begin
          if (s_q == LAST_S) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            s_d     = s_q + ONE;
            j_d     = '0;
            iss     = 1'b1;
            iss_s   = s_q + ONE;
            iss_j   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        s_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase

    iss_sh  = span_shift(iss_md, iss_s);
    rd_en_d = iss;
    rd_a1_d = iss ? top_addr(iss_j, iss_sh) : '0;
    rd_a2_d = iss ? (rd_a1_d + (ONE << iss_sh)) : '0;
    tw_d    = iss ? tw_index(iss_j, iss_sh) : '0;
  end

  // Control state and the registered read-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a1_q <= '0;
      rd_a2_q <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      rd_en_q <= rd_en_d;
      rd_a1_q <= rd_a1_d;
      rd_a2_q <= rd_a2_d;
      tw_q    <= tw_d;
    end
  end

  // Write-side delay line; cleared on reset so an aborted run leaves no writes behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_dly_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        a1_dly_q[i] <= '0;
        a2_dly_q[i] <= '0;
      end
    end else begin
      en_dly_q[0] <= rd_en_q;
      a1_dly_q[0] <= rd_a1_q;
      a2_dly_q[0] <= rd_a2_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        en_dly_q[i] <= en_dly_q[i-1];
        a1_dly_q[i] <= a1_dly_q[i-1];
        a2_dly_q[i] <= a2_dly_q[i-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stage_o     = s_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_1_o = rd_a1_q;
  assign rd_addr_2_o = rd_a2_q;
  assign tw_addr_o   = tw_q;
  assign bf_select_o = sel_q;
  assign wr_en_o     = en_dly_q[PIPE_LAT-1];
  assign wr_addr_1_o = a1_dly_q[PIPE_LAT-1];
  assign wr_addr_2_o = a2_dly_q[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_radix2_scheduler.sv
// Scoreboard bench for ntt_radix2_scheduler (LOG_N=3, PIPE_LAT=3).
module tb_ntt_radix2_scheduler;

  localparam int LOG_N    = 3;
  localparam int PIPE_LAT = 3;
  localparam int N        = 1 << LOG_N;
  localparam int H        = N / 2;
  localparam int RUN      = LOG_N * (H + PIPE_LAT) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic             mode_i = 1'b0;
  logic             busy_o, done_o, rd_en_o, bf_select_o, wr_en_o;
  logic [LOG_N-1:0] stage_o, rd_addr_1_o, rd_addr_2_o, tw_addr_o, wr_addr_1_o, wr_addr_2_o;

  ntt_radix2_scheduler #(.LOG_N(LOG_N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .stage_o(stage_o),
    .rd_en_o(rd_en_o), .rd_addr_1_o(rd_addr_1_o), .rd_addr_2_o(rd_addr_2_o),
    .tw_addr_o(tw_addr_o), .bf_select_o(bf_select_o),
    .wr_en_o(wr_en_o), .wr_addr_1_o(wr_addr_1_o), .wr_addr_2_o(wr_addr_2_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a1;
    int a2;
    int tw;
    int st;
  } ev_t;

  ev_t  rdq[$];
  ev_t  wrq[$];
  int   doneq[$];
  int   total = 0;
  int   bad = 0;
  int   acc_c = -10;
  int   done_c = -10;
  logic cur_mode = 1'b0;
  logic prev_mode = 1'b0;
  ev_t  mon_e;
  int   mon_d;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: enumerate every butterfly of every stage with plain integer arithmetic
  task automatic plan_run(input int c0, input logic md);
    ev_t e;
    int  m, g, k;
    for (int s = 0; s < LOG_N; s++) begin
      m = md ? (1 << s) : (N >> (s + 1));
      for (int j = 0; j < H; j++) begin
        g     = j / m;
        k     = j % m;
        e.cyc = c0 + 1 + s * (H + PIPE_LAT) + j;
        e.a1  = 2 * m * g + k;
        e.a2  = e.a1 + m;
        e.tw  = md ? ((N >> (s + 1)) + g) : ((1 << s) + g);
        e.st  = s;
        rdq.push_back(e);
        e.cyc = e.cyc + PIPE_LAT;
        wrq.push_back(e);
      end
    end
    doneq.push_back(c0 + RUN);
  endtask

  // Drive one cycle of inputs; the model decides whether start is accepted
  task automatic step(input logic st, input logic md);
    start_i = st;
    mode_i  = md;
    if (st && rst_n && cyc > done_c) begin
      prev_mode = cur_mode;
      cur_mode  = md;
      acc_c     = cyc;
      done_c    = cyc + RUN;
      plan_run(cyc, md);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc <= done_c + 1 && n < 200) begin
      step(1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_stage"}, int'(stage_o), 0);
    chk({tag, "_rd_en"}, int'(rd_en_o), 0);
    chk({tag, "_rd_a1"}, int'(rd_addr_1_o), 0);
    chk({tag, "_rd_a2"}, int'(rd_addr_2_o), 0);
    chk({tag, "_tw"}, int'(tw_addr_o), 0);
    chk({tag, "_sel"}, int'(bf_select_o), 0);
    chk({tag, "_wr_en"}, int'(wr_en_o), 0);
    chk({tag, "_wr_a1"}, int'(wr_addr_1_o), 0);
    chk({tag, "_wr_a2"}, int'(wr_addr_2_o), 0);
  endtask

  // Abort whatever is running; expectations are discarded with it
  task automatic pulse_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    acc_c     = -10;
    done_c    = -10;
    cur_mode  = 1'b0;
    prev_mode = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pop and compare whenever the DUT presents a read, write or done
  always @(negedge clk) begin
    if (rd_en_o) begin
      if (rdq.size() > 0) begin
        mon_e = rdq.pop_front();
        chk("rd_cycle", cyc, mon_e.cyc);
        chk("rd_addr_1", int'(rd_addr_1_o), mon_e.a1);
        chk("rd_addr_2", int'(rd_addr_2_o), mon_e.a2);
        chk("tw_addr", int'(tw_addr_o), mon_e.tw);
        chk("stage", int'(stage_o), mon_e.st);
      end else begin
        chk("rd_en_unexpected", 1, 0);
      end
    end
    while (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
      chk("rd_en_missing", 0, 1);
      mon_e = rdq.pop_front();
    end
    if (wr_en_o) begin
      if (wrq.size() > 0) begin
        mon_e = wrq.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_addr_1", int'(wr_addr_1_o), mon_e.a1);
        chk("wr_addr_2", int'(wr_addr_2_o), mon_e.a2);
      end else begin
        chk("wr_en_unexpected", 1, 0);
      end
    end
    while (wrq.size() > 0 && wrq[0].cyc <= cyc) begin
      chk("wr_en_missing", 0, 1);
      mon_e = wrq.pop_front();
    end
    if (done_o) begin
      if (doneq.size() > 0) begin
        mon_d = doneq.pop_front();
        chk("done_cycle", cyc, mon_d);
      end else begin
        chk("done_unexpected", 1, 0);
      end
    end
    while (doneq.size() > 0 && doneq[0] <= cyc) begin
      chk("done_missing", 0, 1);
      mon_d = doneq.pop_front();
    end
    chk("busy", int'(busy_o), (cyc > acc_c && cyc <= done_c) ? 1 : 0);
    chk("bf_select", int'(bf_select_o), int'((cyc > acc_c) ? cur_mode : prev_mode));
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // NTT run, with a flipped-mode start pulse 6 cycles in that must be ignored
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    wait_idle();

    // INTT run
    step(1'b1, 1'b1);
    wait_idle();

    // Reset 10 cycles into a run, quiet period, then a fresh NTT run
    step(1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b0);
    pulse_reset();
    repeat (10) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    wait_idle();

    // start held high: runs go back to back with a random mode each cycle
    repeat (2 * RUN + 4) step(1'b1, 1'($urandom_range(0, 1)));
    wait_idle();

    // Random start/mode traffic with one random-time reset
    for (int i = 0; i < 300; i++) begin
      if (i == 150) pulse_reset();
      step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (4) step(1'b0, 1'b0);

    chk("rd_queue_left", rdq.size(), 0);
    chk("wr_queue_left", wrq.size(), 0);
    chk("done_queue_left", doneq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
